// File: rtl/wb_stage_pkg.sv
// Shared widths and ES-to-WS bus layout for the write-back stage.
package wb_stage_pkg;

  localparam int ES_TO_WS_BUS_WD = 70;
  // Spelling kept for compatibility with existing users of this constant.
  localparam int FORWAED_BUS_WD  = 37;

  localparam int ES_PC_LSB    = 0;
  localparam int ES_RES_LSB   = 32;
  localparam int ES_DEST_LSB  = 64;
  localparam int ES_GR_WE_BIT = 69;

  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } es_to_ws_t;

  function automatic logic [FORWAED_BUS_WD-1:0] fwd_pack(input logic [31:0] data,
                                                         input logic [4:0]  dest);
    return {data, dest};
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Handshake, register-read, forwarding and trace signals around the write-back stage.
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic                       es_to_ws_valid;
  logic [ES_TO_WS_BUS_WD-1:0] es_to_ws_bus;
  logic                       ws_allowin;
  logic [4:0]                 rf_raddr1;
  logic [4:0]                 rf_raddr2;
  logic [31:0]                rf_rdata1;
  logic [31:0]                rf_rdata2;
  logic [FORWAED_BUS_WD-1:0]  wb_forward_bus;
  logic                       trace_ready;
  logic [31:0]                debug_wb_pc;
  logic [3:0]                 debug_wb_rf_we;
  logic [4:0]                 debug_wb_rf_wnum;
  logic [31:0]                debug_wb_rf_wdata;
  logic [63:0]                instret;

  modport slave (
    input  es_to_ws_valid, es_to_ws_bus, rf_raddr1, rf_raddr2, trace_ready,
    output ws_allowin, rf_rdata1, rf_rdata2, wb_forward_bus,
           debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, instret
  );

  modport master (
    output es_to_ws_valid, es_to_ws_bus, rf_raddr1, rf_raddr2, trace_ready,
    input  ws_allowin, rf_rdata1, rf_rdata2, wb_forward_bus,
           debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, instret
  );

endinterface

// File: rtl/wb_stage_regfile.sv
// 32x32 architectural register file: r0 reads as zero, reads bypass the same-cycle write.
module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] r_rf [32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      r_rf[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = r_rf[raddr1];
    if (raddr1 == 5'd0)                rdata1 = '0;
    else if (we && (raddr1 == waddr))  rdata1 = wdata;
  end

  always_comb begin
    rdata2 = r_rf[raddr2];
    if (raddr2 == 5'd0)                rdata2 = '0;
    else if (we && (raddr2 == waddr))  rdata2 = wdata;
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: latches one retiring instruction, commits it to the register file,
// drives the forwarding bus, the commit trace and the retired-instruction counter.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int TRACE_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  wb_stage_if.slave   wb
);

  logic                       r_ws_valid;
  logic [ES_TO_WS_BUS_WD-1:0] r_ws_bus;
  logic [63:0]                r_instret;

  logic        w_ready_go;
  logic        w_allowin;
  logic        w_commit;
  logic        w_gr_we;
  logic [4:0]  w_dest;
  logic [31:0] w_result;
  logic [31:0] w_pc;
  logic        w_rf_we;

  assign w_gr_we  = r_ws_bus[ES_GR_WE_BIT];
  assign w_dest   = r_ws_bus[ES_DEST_LSB +: 5];
  assign w_result = r_ws_bus[ES_RES_LSB +: 32];
  assign w_pc     = r_ws_bus[ES_PC_LSB +: 32];

  assign w_ready_go = (TRACE_EN == 0) || wb.trace_ready;
  assign w_allowin  = !r_ws_valid || w_ready_go;
  assign w_commit   = r_ws_valid && w_ready_go;
  assign w_rf_we    = w_commit && w_gr_we && (w_dest != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ws_valid <= 1'b0;
      r_ws_bus   <= '0;
      r_instret  <= '0;
    end else begin
      if (w_allowin) r_ws_valid <= wb.es_to_ws_valid;
      if (w_allowin && wb.es_to_ws_valid) r_ws_bus <= wb.es_to_ws_bus;
      if (w_commit) r_instret <= r_instret + 64'd1;
    end
  end

  regfile u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (w_rf_we),
    .waddr  (w_dest),
    .wdata  (w_result),
    .raddr1 (wb.rf_raddr1),
    .raddr2 (wb.rf_raddr2),
    .rdata1 (wb.rf_rdata1),
    .rdata2 (wb.rf_rdata2)
  );

  // Forwarding stays live during a trace stall: the held result is already final.
  assign wb.wb_forward_bus = (r_ws_valid && w_gr_we && (w_dest != 5'd0)) ?
                             fwd_pack(w_result, w_dest) : '0;

  assign wb.ws_allowin        = w_allowin;
  assign wb.debug_wb_pc       = w_pc;
  assign wb.debug_wb_rf_we    = {4{w_rf_we}};
  assign wb.debug_wb_rf_wnum  = w_dest;
  assign wb.debug_wb_rf_wdata = w_result;
  assign wb.instret           = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Directed plus randomized bench for wb_stage against a queue-based commit model.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_stage_if ifc ();

  wb_stage #(.TRACE_EN(1)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (ifc)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_rf [32];
  logic [63:0] m_instret;
  es_to_ws_t   m_held [$];
  es_to_ws_t   m_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_instret = '0;
    m_held.delete();
    m_last = '0;
  endtask

  // One cycle: entered just after a falling edge, returns just after the next one.
  task automatic step(input logic v, input logic gw, input logic [4:0] d,
                      input logic [31:0] res, input logic [31:0] pc, input logic tr,
                      input logic [4:0] ra1, input logic [4:0] ra2);
    es_to_ws_t   in;
    es_to_ws_t   h;
    logic        have, commit, wr, allow;
    logic [31:0] e1, e2;
    logic [36:0] efwd;
    in = {gw, d, res, pc};
    ifc.es_to_ws_valid = v;
    ifc.es_to_ws_bus   = in;
    ifc.trace_ready    = tr;
    ifc.rf_raddr1      = ra1;
    ifc.rf_raddr2      = ra2;
    have = (m_held.size() != 0);
    h = '0;
    if (have) h = m_held[0];
    commit = have && tr;
    wr     = commit && h.gr_we && (h.dest != 5'd0);
    allow  = !have || tr;
    efwd   = (have && h.gr_we && (h.dest != 5'd0)) ? {h.final_result, h.dest} : 37'd0;
    e1 = (ra1 == 5'd0) ? 32'd0 : (wr && ra1 == h.dest) ? h.final_result : m_rf[ra1];
    e2 = (ra2 == 5'd0) ? 32'd0 : (wr && ra2 == h.dest) ? h.final_result : m_rf[ra2];
    #1;
    chk("allowin", 64'(ifc.ws_allowin), 64'(allow));
    chk("fwd_bus", 64'(ifc.wb_forward_bus), 64'(efwd));
    chk("dbg_we", 64'(ifc.debug_wb_rf_we), wr ? 64'hF : 64'h0);
    chk("dbg_pc", 64'(ifc.debug_wb_pc), 64'(m_last.pc));
    chk("rdata1", 64'(ifc.rf_rdata1), 64'(e1));
    chk("rdata2", 64'(ifc.rf_rdata2), 64'(e2));
    if (commit) begin
      chk("dbg_wnum", 64'(ifc.debug_wb_rf_wnum), 64'(h.dest));
      chk("dbg_wdata", 64'(ifc.debug_wb_rf_wdata), 64'(h.final_result));
    end
    @(posedge clk);
    if (commit) begin
      if (wr) m_rf[h.dest] = h.final_result;
      m_instret = m_instret + 64'd1;
      void'(m_held.pop_front());
    end
    if (v && allow) begin
      m_held.push_back(in);
      m_last = in;
    end
    @(negedge clk);
    chk("instret", ifc.instret, m_instret);
  endtask

  task automatic bubble(input logic [4:0] ra1, input logic [4:0] ra2);
    step(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, ra1, ra2);
  endtask

  initial begin
    reset = 1'b1;
    ifc.es_to_ws_valid = 1'b0;
    ifc.es_to_ws_bus   = '0;
    ifc.trace_ready    = 1'b1;
    ifc.rf_raddr1      = 5'd3;
    ifc.rf_raddr2      = 5'd0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_allowin", 64'(ifc.ws_allowin), 64'd1);
    chk("rst_fwd", 64'(ifc.wb_forward_bus), 64'd0);
    chk("rst_we", 64'(ifc.debug_wb_rf_we), 64'd0);
    chk("rst_pc", 64'(ifc.debug_wb_pc), 64'd0);
    chk("rst_rdata", 64'(ifc.rf_rdata1), 64'd0);
    chk("rst_instret", ifc.instret, 64'd0);
    reset = 1'b0;

    // Single ALU op with bypass read during commit, then array read.
    step(1'b1, 1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000, 1'b1, 5'd5, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd5, 5'd5);
    chk("t1_instret", ifc.instret, 64'd1);
    bubble(5'd5, 5'd1);

    // Write to r0 still retires.
    step(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h1C00_0004, 1'b1, 5'd0, 5'd0);
    bubble(5'd0, 5'd5);
    chk("t2_instret", ifc.instret, 64'd2);

    // Trace back-pressure with a second instruction offered.
    step(1'b1, 1'b1, 5'd7, 32'hA5A5_0007, 32'h1C00_0008, 1'b0, 5'd7, 5'd0);
    repeat (3) step(1'b1, 1'b1, 5'd8, 32'h5A5A_0008, 32'h1C00_000C, 1'b0, 5'd7, 5'd8);
    step(1'b1, 1'b1, 5'd8, 32'h5A5A_0008, 32'h1C00_000C, 1'b1, 5'd7, 5'd8);
    bubble(5'd7, 5'd8);
    bubble(5'd7, 5'd8);

    // Back-to-back stream r1..r8.
    for (int i = 1; i <= 8; i++)
      step(1'b1, 1'b1, 5'(i), 32'(32'h11 * i), 32'h1C00_0100 + 32'(4 * i), 1'b1,
           5'(i), 5'(i - 1));
    bubble(5'd8, 5'd7);
    for (int i = 1; i <= 8; i += 2) bubble(5'(i), 5'(i + 1));

    // Async reset while a stalled instruction is held.
    step(1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF, 32'h1C00_0200, 1'b0, 5'd9, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd9, 5'd0);
    #2 reset = 1'b1;
    #1;
    chk("mrst_allowin", 64'(ifc.ws_allowin), 64'd1);
    chk("mrst_fwd", 64'(ifc.wb_forward_bus), 64'd0);
    chk("mrst_instret", ifc.instret, 64'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    bubble(5'd9, 5'd5);
    bubble(5'd9, 5'd1);

    // Randomized traffic.
    for (int n = 0; n < 300; n++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           $urandom, $urandom, ($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    bubble(5'd0, 5'd0);

    // Counter wrap.
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.r_instret;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    step(1'b1, 1'b1, 5'd10, 32'h0000_0AAA, 32'h1C00_0300, 1'b1, 5'd10, 5'd0);
    bubble(5'd10, 5'd0);
    chk("wrap_instret", ifc.instret, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage, directly downstream of the execute/memory stage. Latches one retiring instruction per cycle from the `es_to_ws` valid/allowin handshake and commits its result to the architectural register file it owns. It also:
- serves the decode stage's two register read ports;
- drives the write-back forwarding bus back to execute;
- emits a commit trace and retired-instruction count, with optional back-pressure from a trace sink.

## Interface
Parameters:
- `TRACE_EN`, default 1: when 1, commit waits on `trace_ready`; when 0, `trace_ready` is ignored and treated as 1.

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `es_to_ws_valid`  in  1  upstream holds a valid instruction
- `es_to_ws_bus`  in  `ES_TO_WS_BUS_WD` (70)  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
- `ws_allowin`  out  1  stage can accept this cycle
- `rf_raddr1`, `rf_raddr2`  in  5 each  decode read addresses
- `rf_rdata1`, `rf_rdata2`  out  32 each  read data (combinational)
- `wb_forward_bus`  out  `FORWAED_BUS_WD` (37)  {data[36:5], dest[4:0]}
- `trace_ready`  in  1  trace sink can take a commit
- `debug_wb_pc`  out  32  committing pc
- `debug_wb_rf_we`  out  4  byte write enables of the commit
- `debug_wb_rf_wnum`  out  5  committed dest
- `debug_wb_rf_wdata`  out  32  committed data
- `instret`  out  64  retired-instruction count

## Operation
Handshake and capture:
- State: `ws_valid`, the bus register `ws_bus_r`, the regfile (32x32) and `instret`.
- `ws_ready_go = !TRACE_EN || trace_ready`.
- `ws_allowin = !ws_valid || ws_ready_go`.
- Accept: when `ws_allowin`, `ws_valid <= es_to_ws_valid`. When `es_to_ws_valid && ws_allowin`, `ws_bus_r <= es_to_ws_bus`. Otherwise `ws_bus_r` holds.

Commit:
- `commit = ws_valid && ws_ready_go`. Exactly one instruction retires per commit.
- `rf_we = commit && gr_we && dest != 0`. Writes `final_result` to regfile[dest] at the clock edge.
- `instret` increments by 1 on every commit. It wraps from 2^64-1 to 0.

Register file reads:
- Address 0 always returns 0.
- Otherwise, if `rf_we` and `rf_raddrN == dest`, return the write data (write-through bypass).
- Otherwise return the array contents.

Forwarding:
- `wb_forward_bus = (ws_valid && gr_we && dest != 0) ? {final_result, dest} : 0`.
- The bus is driven while the instruction is stalled on `trace_ready`; its data is already final.
- An all-zero bus is harmless, because a compare against r0 yields 0.

Trace outputs:
- `debug_wb_pc = ws_pc`.
- `debug_wb_rf_we = {4{rf_we}}`.
- `debug_wb_rf_wnum = dest`, `debug_wb_rf_wdata = final_result`.
- The sink samples a record only when `commit` is true.

Reset:
- All state clears immediately: `ws_valid = 0`, `ws_bus_r = 0`, all 32 registers = 0, `instret = 0`.
- Outputs after reset: `ws_allowin = 1`, `rf_rdata* = 0`, `wb_forward_bus = 0`, `debug_wb_rf_we = 0`, `debug_wb_pc = 0`.
- Reset asserted mid-stall discards the held instruction: no regfile write, no count.

## Timing
- Occupancy is 1 cycle when unstalled. An instruction accepted at edge k is committed at edge k+1, and `instret` shows the new value after edge k+1.
- Bypass makes the committing value visible on the read ports during the cycle between edges k and k+1.
- Back-to-back operation: with `trace_ready = 1` continuously, one instruction is accepted and one retired every cycle.
- Stall: while `ws_valid && !ws_ready_go`, `ws_allowin = 0`. `ws_bus_r` holds, there is no write and no count. The commit happens on the first edge at which `trace_ready = 1`, and a new instruction may be accepted at that same edge.
- Bubble: `ws_valid = 0` means no write, no count and no trace, and the forward bus is 0.

## Structure
- `define.v` adds the following shared constants; the `FORWAED` spelling is kept for compatibility:
  - `ES_TO_WS_BUS_WD` = 70
  - `FORWAED_BUS_WD` = 37
  - the field offsets of the ES-to-WS bus
- One sub-module, `regfile`, with inputs clk, reset, we, waddr, wdata, raddr1 and raddr2, and outputs rdata1 and rdata2. It implements the r0 rule and the write-through bypass.
- Handshake, commit logic and `instret` live in `wb_stage`.

## Test plan
- **Reset then single ALU op.** Reset, then send {gr_we=1, dest=5, data=0x1234_5678, pc=0x1C00_0000} with `trace_ready = 1`.
  - During the commit cycle: `debug_wb_rf_we = 0xF`, `wnum = 5`, and `rf_rdata1 = 0x12345678` with `raddr1 = 5` (bypass).
  - Next cycle: `instret = 1`, and the regfile holds the value.
- **Write to r0.** dest=0, data=0xFFFF_FFFF: `rf_we = 0`, `debug_wb_rf_we = 0`, reading r0 returns 0, forward bus = 0, `instret` still increments.
- **Trace back-pressure.** Hold `trace_ready = 0` for 3 cycles with an instruction held and a second one offered:
  - `ws_allowin = 0`, no write, `instret` unchanged, forward bus = {data, dest} throughout.
  - When `trace_ready` rises, the first instruction commits and the second is accepted at the same edge.
- **Back-to-back stream.** 8 consecutive instructions writing r1..r8 with 0x11*i: 8 commits in 8 cycles, `instret = 8`, and reading r1..r8 returns the expected values.
- **Async reset mid-stall.** Assert `reset` between edges while a stalled instruction is held: `ws_valid` drops immediately, `ws_allowin = 1`, the target register stays 0 and `instret` = 0.
- **Counter wrap.** Force `instret = 2^64-1` and commit once: `instret = 0`.
